sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port SRAM-like bus between the IF (instruction fetch) and MEM (data access) requesters of the core.
//  Sits between the pipeline's inst/data SRAM ports and the external memory.
//  Non-pipelined: one outstanding access. Raises per-stage stall requests toward CTRL while an access is pending.
// PARAMETERS
//  LATENCY     2  cycles from issue to mem_rdata valid / write done; legal 1..15
//  STARVE_MAX  4  consecutive data grants while inst_req pending before inst is forced to win; legal 1..15
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   asynchronous, active-low reset (0 = reset)
//  inst_req      in   1   IF request; held with inst_wen/addr/wdata stable until inst_gnt
//  inst_wen      in   4   IF byte write enables (0 = read)
//  inst_addr     in   32  IF address
//  inst_wdata    in   32  IF write data
//  inst_gnt      out  1   IF request issued this cycle (1-cycle pulse)
//  inst_rvalid   out  1   IF access complete; inst_rdata valid (1-cycle pulse)
//  inst_rdata    out  32  IF read data, 0 when inst_rvalid=0
//  data_req/data_wen/data_addr/data_wdata  in  1/4/32/32  MEM request, same rules as IF
//  data_gnt/data_rvalid/data_rdata         out 1/1/32     MEM response, same rules as IF
//  mem_en        out  1   memory enable, high in issue cycle only
//  mem_wen       out  4   byte enables of the issued request
//  mem_addr      out  32  address of the issued request
//  mem_wdata     out  32  write data of the issued request
//  mem_rdata     in   32  memory read data, valid LATENCY cycles after issue
//  stallreq_if   out  1   = inst_req & ~inst_rvalid
//  stallreq_mem  out  1   = data_req & ~data_rvalid
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, lat_cnt=0, starve_cnt=0, owner=none; all outputs 0; in-flight response is discarded.
//  - FSM states: IDLE, WAIT_I, WAIT_D.
//  - IDLE, issue cycle T: mem_en/wen/addr/wdata are combinationally driven from the winner; winner gnt=1.
//    Then go to WAIT_x with lat_cnt=LATENCY-1.
//  - Winner selection:
//    - data_req & (~inst_req | starve_cnt<STARVE_MAX) -> data wins.
//    - Otherwise inst_req -> inst wins.
//    - Neither request -> stay IDLE, all mem_* = 0.
//  - starve_cnt:
//    - +1 (saturating at STARVE_MAX) on each data grant while inst_req=1.
//    - Cleared on inst grant, or when inst_req=0 in IDLE.
//  - WAIT_x:
//    - lat_cnt decrements each cycle.
//    - When lat_cnt==0 (cycle T+LATENCY): x_rvalid=1 and x_rdata=mem_rdata (reads); rdata=0 for writes. Next state IDLE.
//    - No issue in the completion cycle; peak throughput is 1 access per LATENCY+1 cycles.
//  - Requester dropping req after gnt does not cancel the access; rvalid still pulses.
//  - stallreq_x stays high from the req cycle through the cycle before rvalid. The rvalid cycle itself is unstalled.
//  - Write acks use the same rvalid timing as reads.
//  - Non-winning requester holds its request; it is not latched internally.
// STRUCTURE
//  - lib/defines.vh additions: ARB_IDLE=2'd0, ARB_WAIT_I=2'd1, ARB_WAIT_D=2'd2, ARB_CNT_WD=4.
//  - Single module; no sub-module (lat_cnt and starve_cnt are small inline counters).
// TESTING
//  1 Reset mid-WAIT_D (LATENCY=3, reset at T+1) -> all outputs 0 immediately; data_rvalid never pulses; next issue only after rst=1.
//  2 Lone inst read addr 0xBFC00000, LATENCY=2, mem_rdata=0x24010001 at T+2
//    -> inst_gnt@T, inst_rvalid=1 & inst_rdata=0x24010001 @T+2, stallreq_if high T..T+1.
//  3 inst_req & data_req together in IDLE -> data_gnt first; inst_gnt at T+LATENCY+1; stallreq_if high throughout.
//  4 Data write wen=4'b0011 addr 0x80000010 wdata 0xDEADBEEF -> mem_wen=4'b0011 at issue; data_rvalid @T+LATENCY, data_rdata=0.
//  5 data_req held high for 6 grants with inst_req high, STARVE_MAX=4 -> inst wins the 5th arbitration; starve_cnt back to 0.
//  6 LATENCY=1, continuous inst_req -> inst_gnt every 2 cycles, no overlap of mem_en with rvalid cycle.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM SRAM port arbiter.
// FSM encoding and counter width are fixed so the arbiter and its users agree.
package sram_port_arbiter_pkg;

  localparam int ARB_CNT_WD = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM bus between the IF and MEM requesters, one access in flight,
// with data priority bounded by a starvation counter that eventually forces an inst grant.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  localparam logic [ARB_CNT_WD-1:0] LAT_INIT   = ARB_CNT_WD'(LATENCY - 1);
  localparam logic [ARB_CNT_WD-1:0] STARVE_LIM = ARB_CNT_WD'(STARVE_MAX);
  localparam logic [ARB_CNT_WD-1:0] CNT_ONE    = ARB_CNT_WD'(1);

  arb_state_e            state_q, state_d;
  logic [ARB_CNT_WD-1:0] lat_cnt_q, lat_cnt_d;
  logic [ARB_CNT_WD-1:0] starve_cnt_q, starve_cnt_d;
  logic                  wr_q, wr_d;
  logic                  data_win, inst_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    wr_d         = wr_q;
    data_win     = 1'b0;
    inst_win     = 1'b0;
    inst_gnt     = 1'b0;
    inst_rvalid  = 1'b0;
    inst_rdata   = '0;
    data_gnt     = 1'b0;
    data_rvalid  = 1'b0;
    data_rdata   = '0;
    mem_en       = 1'b0;
    mem_wen      = '0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ARB_IDLE: begin
        // Issue is also gated by rst so nothing leaks onto the bus while reset is held.
        data_win = rst && data_req && (!inst_req || (starve_cnt_q < STARVE_LIM));
        inst_win = rst && inst_req && !data_win;
        if (data_win) begin
          data_gnt  = 1'b1;
          mem_en    = 1'b1;
          mem_wen   = data_wen;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
          wr_d      = |data_wen;
          lat_cnt_d = LAT_INIT;
          state_d   = ARB_WAIT_D;
          if (inst_req) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + CNT_ONE;
          end else begin
            starve_cnt_d = '0;
          end
        end else if (inst_win) begin
          inst_gnt     = 1'b1;
          mem_en       = 1'b1;
          mem_wen      = inst_wen;
          mem_addr     = inst_addr;
          mem_wdata    = inst_wdata;
          wr_d         = |inst_wen;
          lat_cnt_d    = LAT_INIT;
          state_d      = ARB_WAIT_I;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (lat_cnt_q == '0) begin
          if (state_q == ARB_WAIT_I) begin
            inst_rvalid = 1'b1;
            inst_rdata  = wr_q ? '0 : mem_rdata;
          end else begin
            data_rvalid = 1'b1;
            data_rdata  = wr_q ? '0 : mem_rdata;
          end
          state_d = ARB_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_ONE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign stallreq_if  = rst && inst_req && !inst_rvalid;
  assign stallreq_mem = rst && data_req && !data_rvalid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a cycle table on a LATENCY=2 instance plus
// hand sequences for starvation, reset mid-access (LATENCY=3) and back-to-back issue (LATENCY=1).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [3:0]  inst_wen, data_wen;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, mem_rdata;

  logic        inst_gnt [3];
  logic        inst_rvalid [3];
  logic [31:0] inst_rdata [3];
  logic        data_gnt [3];
  logic        data_rvalid [3];
  logic [31:0] data_rdata [3];
  logic        mem_en [3];
  logic [3:0]  mem_wen [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic        stallreq_if [3];
  logic        stallreq_mem [3];

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, instance 1: LATENCY=3, instance 2: LATENCY=1; all share the inputs.
  for (genvar g = 0; g < 3; g++) begin : gDut
    sram_port_arbiter #(
      .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 3 : 1)),
      .STARVE_MAX(4)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_wen    (inst_wen),
      .inst_addr   (inst_addr),
      .inst_wdata  (inst_wdata),
      .inst_gnt    (inst_gnt[g]),
      .inst_rvalid (inst_rvalid[g]),
      .inst_rdata  (inst_rdata[g]),
      .data_req    (data_req),
      .data_wen    (data_wen),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt[g]),
      .data_rvalid (data_rvalid[g]),
      .data_rdata  (data_rdata[g]),
      .mem_en      (mem_en[g]),
      .mem_wen     (mem_wen[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata),
      .stallreq_if (stallreq_if[g]),
      .stallreq_mem(stallreq_mem[g])
    );
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrd;
    logic        ignt;
    logic        irv;
    logic [31:0] ird;
    logic        dgnt;
    logic        drv;
    logic [31:0] drd;
    logic        men;
    logic [3:0]  mwen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        sif;
    logic        smem;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    inst_req   = v.ireq;
    inst_addr  = v.iaddr;
    inst_wen   = 4'h0;
    inst_wdata = 32'h0;
    data_req   = v.dreq;
    data_wen   = v.dwen;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
    mem_rdata  = v.mrd;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".inst_gnt"},     32'(inst_gnt[0]),     32'(v.ignt));
    chk({p, ".inst_rvalid"},  32'(inst_rvalid[0]),  32'(v.irv));
    chk({p, ".inst_rdata"},   inst_rdata[0],        v.ird);
    chk({p, ".data_gnt"},     32'(data_gnt[0]),     32'(v.dgnt));
    chk({p, ".data_rvalid"},  32'(data_rvalid[0]),  32'(v.drv));
    chk({p, ".data_rdata"},   data_rdata[0],        v.drd);
    chk({p, ".mem_en"},       32'(mem_en[0]),       32'(v.men));
    chk({p, ".mem_wen"},      32'(mem_wen[0]),      32'(v.mwen));
    chk({p, ".mem_addr"},     mem_addr[0],          v.maddr);
    chk({p, ".mem_wdata"},    mem_wdata[0],         v.mwdata);
    chk({p, ".stallreq_if"},  32'(stallreq_if[0]),  32'(v.sif));
    chk({p, ".stallreq_mem"}, 32'(stallreq_mem[0]), 32'(v.smem));
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Lone inst read at the boot vector (issue, wait, complete, idle).
    vecs[0]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFC00000, 32'h0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h24010001,
                 1'b0, 1'b1, 32'h24010001, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h11111111,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    // Simultaneous requests: data first, inst at T+LATENCY+1, data drops req after its grant.
    vecs[4]  = '{1'b1, 32'h1000, 1'b1, 4'h0, 32'h2000, 32'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h2000, 32'h0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h1000, 32'h0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h1000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D,
                 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    // Partial data write: ack with the read timing and zero rdata.
    vecs[11] = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h80000010, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h80000010, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h80000010, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h80000010, 32'hDEADBEEF, 32'hFFFFFFFF,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};

    // Reset with both requests asserted: every output must stay low.
    rst = 1'b0;
    inst_req = 1'b1; inst_wen = 4'h0; inst_addr = 32'h44; inst_wdata = 32'h0;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h88; data_wdata = 32'h99;
    mem_rdata = 32'h0;
    @(negedge clk);
    #1;
    chk("rst.mem_en", 32'(mem_en[0]), 32'h0);
    chk("rst.inst_gnt", 32'(inst_gnt[0]), 32'h0);
    chk("rst.data_gnt", 32'(data_gnt[0]), 32'h0);
    chk("rst.mem_addr", mem_addr[0], 32'h0);
    chk("rst.stallreq_if", 32'(stallreq_if[0]), 32'h0);
    chk("rst.stallreq_mem", 32'(stallreq_mem[0]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;

    $display("[TB] table vectors, LATENCY=2");
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Starvation: with both requests held, inst must win every 5th arbitration.
    $display("[TB] starvation sequence, STARVE_MAX=4");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h3000;
      data_req = 1'b1; data_addr = 32'h4000; data_wen = 4'h0;
      #1;
      chk($sformatf("starve%0d.data_gnt", k), 32'(data_gnt[0]), 32'((k % 5) != 4));
      chk($sformatf("starve%0d.inst_gnt", k), 32'(inst_gnt[0]), 32'((k % 5) == 4));
      chk($sformatf("starve%0d.mem_addr", k), mem_addr[0], ((k % 5) == 4) ? 32'h3000 : 32'h4000);
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b0;

    // Reset one cycle after a data issue on the LATENCY=3 instance.
    $display("[TB] reset mid-access, LATENCY=3");
    resetPulse();
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h6000; data_wen = 4'h0; mem_rdata = 32'h0;
    #1;
    chk("rstmid.issue_gnt", 32'(data_gnt[1]), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.mem_en", 32'(mem_en[1]), 32'h0);
    chk("rstmid.data_gnt", 32'(data_gnt[1]), 32'h0);
    chk("rstmid.stallreq_mem", 32'(stallreq_mem[1]), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rdata = 32'hBAD0BAD0;
      #1;
      chk($sformatf("rstmid%0d.data_rvalid", c), 32'(data_rvalid[1]), 32'h0);
      chk($sformatf("rstmid%0d.data_rdata", c), data_rdata[1], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    mem_rdata = 32'h0;
    #1;
    chk("rstmid.reissue_gnt", 32'(data_gnt[1]), 32'h1);
    chk("rstmid.reissue_addr", mem_addr[1], 32'h6000);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("rstmid.r1_rvalid", 32'(data_rvalid[1]), 32'h0);
    @(negedge clk);
    #1;
    chk("rstmid.r2_rvalid", 32'(data_rvalid[1]), 32'h0);
    @(negedge clk);
    mem_rdata = 32'h600D600D;
    #1;
    chk("rstmid.r3_rvalid", 32'(data_rvalid[1]), 32'h1);
    chk("rstmid.r3_rdata", data_rdata[1], 32'h600D600D);

    // LATENCY=1 with continuous inst_req: grant and completion alternate.
    $display("[TB] back-to-back inst reads, LATENCY=1");
    resetPulse();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h5000; inst_wen = 4'h0;
      data_req = 1'b0;
      mem_rdata = 32'h12345678 + 32'(c);
      #1;
      chk($sformatf("lat1_%0d.inst_gnt", c), 32'(inst_gnt[2]), 32'((c % 2) == 0));
      chk($sformatf("lat1_%0d.mem_en", c), 32'(mem_en[2]), 32'((c % 2) == 0));
      chk($sformatf("lat1_%0d.inst_rvalid", c), 32'(inst_rvalid[2]), 32'((c % 2) == 1));
      chk($sformatf("lat1_%0d.inst_rdata", c), inst_rdata[2],
          ((c % 2) == 1) ? (32'h12345678 + 32'(c)) : 32'h0);
      chk($sformatf("lat1_%0d.stallreq_if", c), 32'(stallreq_if[2]), 32'((c % 2) == 0));
    end
    @(negedge clk);
    inst_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
